// File: rtl/spi_shifter.sv
// -----------------------------------------------------------------------------
// spi_shifter
//
// Bit-level SPI engine that sits behind the spi_master register block.
// A one-cycle start strobe latches the byte to send and the SPI mode. The
// block then generates SCLK for that mode, serialises the byte on MOSI and
// captures MISO. When it is finished it returns the received byte together
// with a one-cycle done pulse. Slave select is owned by spi_master and is not
// driven here.
//
// Optional build macro: SPI_LSB_FIRST_EN
//   Defined   : adds i_lsb_first, which is sampled with i_start. When it is 1
//               the byte goes out tx[0] first and the receive register shifts
//               right.
//   Undefined : MSB-first only.
//
// Parameters
//   CLK_FREQ   system clock frequency (Hz)
//   SCLK_FREQ  target SCLK frequency (Hz)
//
// Ports
//   i_clk        system clock
//   i_rst        asynchronous reset, active-high
//   i_start      one-cycle request to begin a transfer (ignored while busy)
//   i_mode[1:0]  SPI mode: bit1 = CPOL, bit0 = CPHA
//   i_data[7:0]  byte to transmit, sampled with i_start
//   i_lsb_first  (SPI_LSB_FIRST_EN only) bit order, sampled with i_start
//   o_data[7:0]  last received byte, valid from the o_done cycle
//   o_busy       transfer in progress
//   o_done       one-cycle pulse: transfer complete
//   o_SCLK       SPI clock
//   o_MOSI       master out, slave in
//   i_MISO       master in, slave out
// -----------------------------------------------------------------------------
module spi_shifter #(
    parameter int CLK_FREQ  = 48_000_000,
    parameter int SCLK_FREQ = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [1:0] i_mode,
    input  logic [7:0] i_data,
`ifdef SPI_LSB_FIRST_EN
    input  logic       i_lsb_first,
`endif
    output logic [7:0] o_data,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_SCLK,
    output logic       o_MOSI,
    input  logic       i_MISO
);

    // Clocks per SCLK half-period, never less than one.
    localparam int HALF_RAW = CLK_FREQ / (2 * SCLK_FREQ);
    localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int CW       = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TAIL  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] half_cnt;
    logic [3:0]    edge_cnt;
    logic [7:0]    tx_q;
    logic [7:0]    rx_q;
    logic [1:0]    mode_q;
    logic          lsb_q;
    logic          lsb_in;
    logic          leading;
    logic          sample_edge;
    logic [7:0]    tx_next;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_in = i_lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    // Bit that goes on the wire first for a given shift register contents.
    function automatic logic out_bit(input logic [7:0] tx, input logic lsb);
        return lsb ? tx[0] : tx[7];
    endfunction

    // Advance the transmit register by one bit in the selected order.
    function automatic logic [7:0] tx_shift(input logic [7:0] tx, input logic lsb);
        return lsb ? {1'b0, tx[7:1]} : {tx[6:0], 1'b0};
    endfunction

    // Insert one received bit; MSB-first fills from the right.
    function automatic logic [7:0] rx_shift(input logic [7:0] rx, input logic miso,
                                            input logic lsb);
        return lsb ? {miso, rx[7:1]} : {rx[6:0], miso};
    endfunction

    // edge_cnt holds the number of SCLK edges already produced, so the edge
    // about to happen is a leading edge when that count is even. The sampling
    // edge is the leading edge for CPHA=0 and the trailing edge for CPHA=1.
    assign leading     = ~edge_cnt[0];
    assign sample_edge = leading ^ mode_q[0];
    assign tx_next     = tx_shift(tx_q, lsb_q);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            half_cnt <= '0;
            edge_cnt <= 4'd0;
            tx_q     <= 8'h00;
            rx_q     <= 8'h00;
            mode_q   <= 2'b00;
            lsb_q    <= 1'b0;
            o_data   <= 8'h00;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_SCLK   <= 1'b0;
            o_MOSI   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    // Idle level tracks CPOL so SCLK is already parked
                    // correctly when a transfer begins.
                    o_SCLK <= i_mode[1];
                    if (i_start) begin
                        tx_q     <= i_data;
                        mode_q   <= i_mode;
                        lsb_q    <= lsb_in;
                        rx_q     <= 8'h00;
                        half_cnt <= '0;
                        edge_cnt <= 4'd0;
                        o_busy   <= 1'b1;
                        o_MOSI   <= out_bit(i_data, lsb_in);
                        state    <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt <= '0;
                        o_SCLK   <= ~o_SCLK;
                        edge_cnt <= edge_cnt + 4'd1;
                        if (sample_edge) begin
                            rx_q <= rx_shift(rx_q, i_MISO, lsb_q);
                        end else if (edge_cnt != 4'd0) begin
                            // For CPHA=1 the first leading edge presents the
                            // bit already on MOSI, so no shift happens there.
                            tx_q   <= tx_next;
                            o_MOSI <= out_bit(tx_next, lsb_q);
                        end
                        if (edge_cnt == 4'd15) begin
                            state <= TAIL;
                        end
                    end else begin
                        half_cnt <= half_cnt + CW'(1);
                    end
                end

                TAIL: begin
                    // One extra half-period with SCLK parked gives the slave
                    // hold time before the result is handed back.
                    if (half_cnt == HALF_LAST) begin
                        half_cnt <= '0;
                        o_data   <= rx_q;
                        o_busy   <= 1'b0;
                        o_done   <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        half_cnt <= half_cnt + CW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_shifter.sv
module tb_spi_shifter;

    localparam int HALF       = 2;             // 4 MHz / (2 * 1 MHz)
    localparam int BUSY_CYC   = 17 * HALF;     // cycles o_busy is high
    localparam int DONE_EDGES = 17 * HALF;     // clock edges from start sample to done visible
    localparam int N_EDGES    = 16;

    typedef struct packed {
        logic [7:0]  tx;
        logic [7:0]  sb;
        logic [1:0]  mode;
        logic        lsb;
        logic        loop;
        int unsigned start_cyc;
    } xfer_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic [7:0] data_in;
    logic       lsb_first;
    logic [7:0] data_out;
    logic       busy;
    logic       done;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       loop_sel;
    logic       slave_miso;

    int unsigned cyc;
    int          n_checks;
    int          n_fail;
    int          done_cnt;
    int          exp_done;
    xfer_t       q[$];

    assign miso = loop_sel ? mosi : slave_miso;

    spi_shifter #(
        .CLK_FREQ (4_000_000),
        .SCLK_FREQ(1_000_000)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_mode     (mode),
        .i_data     (data_in),
`ifdef SPI_LSB_FIRST_EN
        .i_lsb_first(lsb_first),
`endif
        .o_data     (data_out),
        .o_busy     (busy),
        .o_done     (done),
        .o_SCLK     (sclk),
        .o_MOSI     (mosi),
        .i_MISO     (miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_msg(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Slave model and scoreboard monitor. It behaves like an SPI slave: it
    // captures MOSI on the sampling edges of the mode and presents its own byte
    // MSB first, changing MISO on the opposite edges.
    initial begin : monitor
        xfer_t      cur;
        logic       active, prev_busy, prev_sclk, is_lead, is_sample;
        logic [7:0] sbits, cap, exp_rx, exp_cap;
        int         edges, busy_run;
        active = 1'b0; prev_busy = 1'b0; prev_sclk = 1'b0;
        sbits = 8'h00; cap = 8'h00; edges = 0; busy_run = 0; cur = '0;
        loop_sel = 1'b0; slave_miso = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0; prev_busy = 1'b0; prev_sclk = sclk; busy_run = 0;
            end else begin
                if (busy && !prev_busy) begin
                    if (q.size() == 0) begin
                        fail_msg("busy_without_request");
                    end else begin
                        cur = q[0]; active = 1'b1; edges = 0; cap = 8'h00;
                        sbits = cur.sb; loop_sel = cur.loop;
                        if (!cur.mode[0]) begin
                            slave_miso = sbits[7];
                            sbits = {sbits[6:0], 1'b0};
                        end
                    end
                end
                if (busy) busy_run++;
                if (active && busy && (sclk !== prev_sclk)) begin
                    edges++;
                    is_lead   = (edges % 2) == 1;
                    is_sample = cur.mode[0] ? !is_lead : is_lead;
                    if (is_sample) begin
                        cap = {cap[6:0], mosi};
                    end else begin
                        slave_miso = sbits[7];
                        sbits = {sbits[6:0], 1'b0};
                    end
                end
                if (done) begin
                    done_cnt++;
                    if (!active) begin
                        fail_msg("done_without_transfer");
                    end else begin
                        exp_rx  = cur.loop ? cur.tx : (cur.lsb ? rev8(cur.sb) : cur.sb);
                        exp_cap = cur.lsb ? rev8(cur.tx) : cur.tx;
                        chk("rx_data", data_out, exp_rx);
                        chk("mosi_bits", cap, exp_cap);
                        chk("sclk_edges", edges, N_EDGES);
                        chk("busy_cycles", busy_run, BUSY_CYC);
                        chk("done_latency", cyc - cur.start_cyc, DONE_EDGES);
                        chk("busy_at_done", busy, 1'b0);
                        chk("sclk_park", sclk, cur.mode[1]);
                        void'(q.pop_front());
                        active = 1'b0;
                    end
                end
                if (!busy) busy_run = 0;
                prev_busy = busy;
                prev_sclk = sclk;
            end
        end
    end

    task automatic do_start(input logic [1:0] m, input logic [7:0] tx, input logic [7:0] sb,
                            input logic lp, input logic lsb, input bit settle);
        xfer_t e;
        if (settle) begin
            @(negedge clk);
            mode = m;
            repeat (2) @(negedge clk);
            chk("sclk_idle", sclk, m[1]);
        end else begin
            mode = m;
        end
        e.tx = tx; e.sb = sb; e.mode = m; e.lsb = lsb; e.loop = lp;
        e.start_cyc = cyc + 1;
        q.push_back(e);
        exp_done++;
        data_in = tx; lsb_first = lsb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Scramble inputs while busy and optionally re-pulse start at a given cycle.
    task automatic mutate_busy(input int pulse_at);
        for (int j = 2; j <= 30; j++) begin
            @(negedge clk);
            mode    = 2'($urandom_range(0, 3));
            data_in = 8'($urandom);
            start   = (j == pulse_at);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 200);
        if (done !== 1'b1) fail_msg({nm, "_timeout"});
    endtask

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [1:0] m;
        logic       lsb;
        n_checks = 0; n_fail = 0; done_cnt = 0; exp_done = 0;
        rst = 1'b1; start = 1'b0; mode = 2'b00; data_in = 8'h00; lsb_first = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", data_out, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        rst = 1'b0;

        // Mode 0 loopback.
        do_start(2'd0, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b1);
        wait_done("mode0");
        // Mode 3, MISO held high.
        do_start(2'd3, 8'h3C, 8'hFF, 1'b0, 1'b0, 1'b1);
        wait_done("mode3");
        repeat (3) @(negedge clk);
        chk("mode3_idle_high", sclk, 1'b1);
        chk("mosi_hold_idle", mosi, 1'b0);
        // Mode 1, slave sends 0x5A.
        do_start(2'd1, 8'h81, 8'h5A, 1'b0, 1'b0, 1'b1);
        wait_done("mode1");
        // Start re-pulsed at cycle 10 with 0xFF must be ignored.
        do_start(2'd0, 8'h3C, 8'hC3, 1'b0, 1'b0, 1'b1);
        repeat (9) @(negedge clk);
        data_in = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignored_start");
        // Reset at cycle 15 aborts the transfer.
        do_start(2'd2, 8'h96, 8'h69, 1'b0, 1'b0, 1'b1);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        q.delete();
        exp_done--;
        @(posedge clk);
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_sclk", sclk, 1'b0);
        chk("abort_mosi", mosi, 1'b0);
        chk("abort_data", data_out, 8'h00);
        chk("abort_done", done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        // Fresh transfer after the abort.
        do_start(2'd2, 8'h5B, 8'hE4, 1'b0, 1'b0, 1'b1);
        wait_done("after_abort");
        // Start issued in the done cycle is accepted.
        do_start(2'd1, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b1);
        wait_done("b2b_first");
        do_start(2'd1, 8'hE7, 8'h18, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_single_done", done, 1'b0);
        wait_done("b2b_second");
`ifdef SPI_LSB_FIRST_EN
        do_start(2'd0, 8'h01, 8'h00, 1'b1, 1'b1, 1'b1);
        wait_done("lsb_loop");
        do_start(2'd3, 8'hC8, 8'h35, 1'b0, 1'b1, 1'b1);
        wait_done("lsb_slave");
`endif
        // Randomised transfers with input scrambling while busy.
        for (int i = 0; i < 20; i++) begin
            m = 2'($urandom_range(0, 3));
`ifdef SPI_LSB_FIRST_EN
            lsb = 1'($urandom_range(0, 1));
`else
            lsb = 1'b0;
`endif
            do_start(m, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), lsb, 1'b1);
            if ($urandom_range(0, 1) == 1) mutate_busy(int'($urandom_range(2, 30)));
            wait_done("random");
        end

        repeat (5) @(negedge clk);
        chk("done_count", done_cnt, exp_done);
        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
